// File: rtl/commutation_sequencer.sv
// Open-loop six-step commutation controller for a three-switch bridge.
// Handles alignment, direction, dynamic braking, faults and the bridge keep-alive toggle.
module commutation_sequencer #(
  parameter int unsigned PERIOD_W     = 24,
  parameter int unsigned MIN_PERIOD   = 400,
  parameter int unsigned ALIGN_CYCLES = 4000000,
  parameter int unsigned WDOG_HALF    = 262144
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                dir,
  input  logic                brake,
  input  logic                fault_in,
  input  logic [PERIOD_W-1:0] period,
  input  logic                period_load,
  output logic [2:0]          sw_cmd,
  output logic                watchdog_out,
  output logic [2:0]          step_idx,
  output logic                running,
  output logic                fault
);

  localparam int unsigned ALIGN_W = (ALIGN_CYCLES > 1) ? $clog2(ALIGN_CYCLES) : 1;
  localparam int unsigned WDOG_W  = (WDOG_HALF > 1) ? $clog2(WDOG_HALF) : 1;

  localparam logic [PERIOD_W-1:0] MIN_P      = PERIOD_W'(MIN_PERIOD);
  localparam logic [ALIGN_W-1:0]  ALIGN_LAST = ALIGN_W'(ALIGN_CYCLES - 1);
  localparam logic [WDOG_W-1:0]   WDOG_LAST  = WDOG_W'(WDOG_HALF - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_RUN,
    ST_BRAKE,
    ST_FAULT
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [ALIGN_W-1:0]  align_cnt;
  logic [PERIOD_W-1:0] step_cnt;
  logic [PERIOD_W-1:0] shadow;
  logic [PERIOD_W-1:0] pending;
  logic                pending_vld;
  logic [WDOG_W-1:0]   wdog_cnt;

  logic                step_end;
  logic                apply_now;
  logic                wdog_active;
  logic [PERIOD_W-1:0] period_clamped;
  logic [2:0]          idx_adv;
  logic [2:0]          idx_nx;
  logic [2:0]          sw_nx;

  function automatic logic [2:0] step_pattern(input logic [2:0] idx);
    case (idx)
      3'd0:    step_pattern = 3'b100;
      3'd1:    step_pattern = 3'b110;
      3'd2:    step_pattern = 3'b010;
      3'd3:    step_pattern = 3'b011;
      3'd4:    step_pattern = 3'b001;
      3'd5:    step_pattern = 3'b101;
      default: step_pattern = 3'b111;
    endcase
  endfunction

  // Priority: fault_in, then FAULT stickiness, then !enable, then brake.
  always_comb begin
    state_nx = state;
    if (fault_in) begin
      state_nx = ST_FAULT;
    end else if (state == ST_FAULT) begin
      if (!enable) state_nx = ST_IDLE;
    end else if (!enable) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_BRAKE: state_nx = brake ? ST_BRAKE : ST_ALIGN;
        ST_ALIGN: begin
          if (brake)                       state_nx = ST_BRAKE;
          else if (align_cnt == ALIGN_LAST) state_nx = ST_RUN;
          else                             state_nx = ST_ALIGN;
        end
        ST_RUN:  state_nx = brake ? ST_BRAKE : ST_RUN;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    step_end       = (state == ST_RUN) && (state_nx == ST_RUN) &&
                     (step_cnt == (shadow - PERIOD_W'(1)));
    apply_now      = (state != ST_RUN) || step_end;
    wdog_active    = (state == ST_ALIGN) || (state == ST_RUN) || (state == ST_BRAKE);
    period_clamped = (period < MIN_P) ? MIN_P : period;

    if (dir) idx_adv = (step_idx == 3'd0) ? 3'd5 : step_idx - 3'd1;
    else     idx_adv = (step_idx == 3'd5) ? 3'd0 : step_idx + 3'd1;

    if ((state_nx == ST_ALIGN) && (state != ST_ALIGN)) idx_nx = 3'd0;
    else if (step_end)                                 idx_nx = idx_adv;
    else                                               idx_nx = step_idx;

    if ((state_nx == ST_ALIGN) || (state_nx == ST_RUN)) sw_nx = step_pattern(idx_nx);
    else                                                sw_nx = 3'b111;
  end

  // Outputs are computed from the next state so sw_cmd and step_idx update on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      sw_cmd   <= '1;
      step_idx <= '0;
      running  <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_nx;
      sw_cmd   <= sw_nx;
      step_idx <= idx_nx;
      running  <= (state_nx == ST_RUN);
      fault    <= (state_nx == ST_FAULT);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      align_cnt <= '0;
      step_cnt  <= '0;
    end else begin
      if ((state == ST_ALIGN) && (state_nx == ST_ALIGN)) align_cnt <= align_cnt + ALIGN_W'(1);
      else                                               align_cnt <= '0;

      if ((state == ST_RUN) && (state_nx == ST_RUN))
        step_cnt <= step_end ? '0 : step_cnt + PERIOD_W'(1);
      else
        step_cnt <= '0;
    end
  end

  // A load landing on a boundary is written straight to shadow, so the ending step keeps the old length.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow      <= MIN_P;
      pending     <= MIN_P;
      pending_vld <= 1'b0;
    end else if (period_load) begin
      pending <= period_clamped;
      if (apply_now) begin
        shadow      <= period_clamped;
        pending_vld <= 1'b0;
      end else begin
        pending_vld <= 1'b1;
      end
    end else if (pending_vld && apply_now) begin
      shadow      <= pending;
      pending_vld <= 1'b0;
    end
  end

  // Every state entry restarts the keep-alive phase; the first toggle lands one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt     <= '0;
      watchdog_out <= 1'b0;
    end else if (state_nx != state) begin
      wdog_cnt <= '0;
    end else if (wdog_active) begin
      wdog_cnt <= (wdog_cnt == WDOG_LAST) ? '0 : wdog_cnt + WDOG_W'(1);
      if (wdog_cnt == '0) watchdog_out <= ~watchdog_out;
    end
  end

endmodule

// File: tb/tb_commutation_sequencer.sv
// Scoreboard bench for commutation_sequencer: expected sw_cmd edges and keep-alive toggles
// are queued with their cycle numbers and matched against what the outputs actually do.
module tb_commutation_sequencer;

  localparam int unsigned PW    = 24;
  localparam int unsigned MINP  = 400;
  localparam int          ALIGN = 100;
  localparam int          WDH   = 64;

  localparam logic [2:0] PAT [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          dir = 1'b0;
  logic          brake = 1'b0;
  logic          fault_in = 1'b0;
  logic [PW-1:0] period = '0;
  logic          period_load = 1'b0;
  logic [2:0]    sw_cmd;
  logic          watchdog_out;
  logic [2:0]    step_idx;
  logic          running;
  logic          fault;

  commutation_sequencer #(
    .PERIOD_W    (PW),
    .MIN_PERIOD  (MINP),
    .ALIGN_CYCLES(ALIGN),
    .WDOG_HALF   (WDH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .dir         (dir),
    .brake       (brake),
    .fault_in    (fault_in),
    .period      (period),
    .period_load (period_load),
    .sw_cmd      (sw_cmd),
    .watchdog_out(watchdog_out),
    .step_idx    (step_idx),
    .running     (running),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         t;
    logic [2:0] sw;
    bit         ci;
    logic [2:0] idx;
  } sw_ev_t;

  sw_ev_t sw_q[$];
  int     wd_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  bit     mon_en = 1'b0;
  logic [2:0] prev_sw;
  logic       prev_wd;

  int seq[16] = '{0, 1, 2, 3, 4, 5, 0, 1, 2, 3, 2, 1, 0, 5, 4, 3};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_sw(input int t, input logic [2:0] sw, input bit ci, input logic [2:0] idx);
    sw_ev_t e;
    e.t = t; e.sw = sw; e.ci = ci; e.idx = idx;
    sw_q.push_back(e);
  endtask

  task automatic push_wd(input int lo, input int hi);
    for (int e = lo; e <= hi; e += WDH) wd_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    sw_ev_t ev;
    int     t;
    if (mon_en) begin
      if (sw_cmd !== prev_sw) begin
        check("sw_event_due", sw_q.size() > 0, 1);
        if (sw_q.size() > 0) begin
          ev = sw_q.pop_front();
          check("sw_time", cyc, ev.t);
          check("sw_val", sw_cmd, ev.sw);
          if (ev.ci) check("step_idx", step_idx, ev.idx);
        end
      end
      if (watchdog_out !== prev_wd) begin
        check("wd_event_due", wd_q.size() > 0, 1);
        if (wd_q.size() > 0) begin
          t = wd_q.pop_front();
          check("wd_time", cyc, t);
        end
      end
    end
    prev_sw = sw_cmd;
    prev_wd = watchdog_out;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int   k, f, k2, e3, e4, b, e5, e7, r;
    int   tt[16];
    logic wd_hold;

    repeat (3) @(posedge clk);
    #1;
    check("rst_sw", sw_cmd, 3'b111);
    check("rst_idx", step_idx, 0);
    check("rst_running", running, 0);
    check("rst_fault", fault, 0);
    check("rst_wd", watchdog_out, 0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Phase 1: align, forward run, clamped load, reverse, load on boundary, fault
    period = 1000; period_load = 1'b1;
    wait_cyc(cyc + 1);
    period_load = 1'b0;
    wait_cyc(cyc + 2);
    k = cyc;
    tt[0] = k + 1 + ALIGN;
    for (int n = 1; n <= 7; n++)  tt[n] = tt[0] + n * 1000;
    for (int n = 8; n <= 14; n++) tt[n] = tt[n-1] + 400;
    tt[15] = tt[14] + 600;
    f = tt[15] + 201;
    push_sw(k + 1, PAT[0], 1'b1, 3'd0);
    for (int n = 1; n <= 15; n++) push_sw(tt[n], PAT[seq[n]], 1'b1, 3'(seq[n]));
    push_sw(f, 3'b111, 1'b0, 3'd0);
    push_wd(k + 2, tt[0] - 1);
    push_wd(tt[0] + 1, f - 1);
    enable = 1'b1;

    wait_cyc(tt[0] + 300);
    check("run_running", running, 1);
    check("run_fault", fault, 0);

    wait_cyc(tt[6] + 300);
    period = 50; period_load = 1'b1;
    wait_cyc(tt[6] + 301);
    period_load = 1'b0;

    wait_cyc(tt[9] + 100);
    dir = 1'b1;

    wait_cyc(tt[14] - 1);
    period = 600; period_load = 1'b1;
    wait_cyc(tt[14]);
    period_load = 1'b0;

    wait_cyc(tt[15] + 200);
    fault_in = 1'b1;
    wait_cyc(f);
    fault_in = 1'b0;
    check("flt_fault", fault, 1);
    check("flt_running", running, 0);
    check("flt_sw", sw_cmd, 3'b111);
    wd_hold = watchdog_out;
    wait_cyc(f + 150);
    check("flt_sticky", fault, 1);
    check("flt_wd_frozen", watchdog_out, wd_hold);
    enable = 1'b0;
    wait_cyc(f + 152);
    check("flt_cleared", fault, 0);
    check("idle_sw", sw_cmd, 3'b111);

    // Phase 2: forward run, brake, release to align, reset mid-run
    dir = 1'b0;
    k2 = f + 155;
    wait_cyc(k2);
    e3 = k2 + 1;
    e4 = e3 + ALIGN;
    b  = e4 + 651;
    e5 = b + 200;
    e7 = e5 + ALIGN;
    r  = e7 + 300;
    push_sw(e3, PAT[0], 1'b1, 3'd0);
    push_sw(e4 + 600, PAT[1], 1'b1, 3'd1);
    push_sw(b, 3'b111, 1'b0, 3'd0);
    push_sw(e5, PAT[0], 1'b1, 3'd0);
    push_wd(e3 + 1, e4 - 1);
    push_wd(e4 + 1, b - 1);
    push_wd(b + 1, e5 - 1);
    push_wd(e5 + 1, e7 - 1);
    push_wd(e7 + 1, r - 1);
    enable = 1'b1;

    wait_cyc(e4 + 650);
    brake = 1'b1;
    wait_cyc(b);
    check("brk_running", running, 0);
    check("brk_fault", fault, 0);
    wait_cyc(b + 199);
    brake = 1'b0;

    wait_cyc(r);
    check("pre_rst_running", running, 1);
    mon_en = 1'b0;
    reset_n = 1'b0;
    #2;
    check("async_rst_sw", sw_cmd, 3'b111);
    check("async_rst_idx", step_idx, 0);
    check("async_rst_running", running, 0);
    check("async_rst_wd", watchdog_out, 0);
    enable = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_sw", sw_cmd, 3'b111);
    check("sw_q_left", sw_q.size(), 0);
    check("wd_q_left", wd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
